data_bridge: RTL and testbench
==============================

Name: data_bridge

Overview:
- Responder side of the core's data-memory port: consumes m_data_addr / m_data_wdata / m_data_byteen and returns m_data_rdata.
- Decodes each access to either an internal word-wide data RAM or a memory-mapped countdown timer (TC) with an interrupt output.
- Sits beside the pipelined core at the top level; the core's M stage still performs byte/half extraction and sign extension.

Parameters:
- DM_WORDS, 3072, number of 32-bit RAM words; RAM spans 0x0000_0000 to 4*DM_WORDS-1.
- TC_BASE, 32'h0000_7F00, base address of the 3-word timer register block.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- m_data_addr  in  32  byte address from the M stage.
- m_data_wdata  in  32  lane-aligned write data.
- m_data_byteen  in  4  per-byte write enables; 4'b0000 means read/no write.
- m_data_rdata  out  32  word read data, combinational from m_data_addr.
- irq  out  1  timer interrupt request.

Behaviour:
- Address decode uses word index addr[31:2]; addr[1:0] is ignored.
  - RAM hit: addr < 4*DM_WORDS.
  - TC hit: addr in [TC_BASE, TC_BASE+11].
  - Anything else is unmapped: read returns 0, writes are dropped.
- Reads: m_data_rdata is purely combinational, with zero latency and the value valid in the same cycle. A RAM word written at edge N is visible from edge N onward.
- Writes: committed at posedge for each lane i where m_data_byteen[i]=1. Unselected lanes keep their old value.
- RAM has no reset and is initialised to zeros at time 0. Timer state resets asynchronously.
- TC registers:
  - CTRL at +0, read/write, bits [3:0], upper bits read 0. Bit 0 EN, bits [2:1] MODE (00 one-shot, 01 auto-reload, others behave as 00), bit 3 IM (interrupt mask, 1 = enabled).
  - PRESET at +4, read/write, 32 bits.
  - COUNT at +8, read-only; writes are ignored.
  - Byte-lane merge applies to CTRL and PRESET.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq=0. m_data_rdata follows decode (RAM word 0 at addr 0).
- Timer FSM, state held in a 2-bit register:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT<=PRESET, go to CNT.
  - CNT: if EN=0, go to IDLE with COUNT held. Else if COUNT>1, decrement COUNT. Else (COUNT<=1) set COUNT<=0 and go to INT.
  - INT, MODE 00: clear EN, set irq_flag, go to IDLE.
  - INT, MODE 01: set irq_flag for exactly this one cycle, go to LOAD.
  - irq = IM & irq_flag, registered.
  - One-shot irq_flag stays high until any CTRL write.
- Latency: with EN set at edge N and PRESET=P≥1, the FSM reaches INT at edge N+P+2 and irq rises at edge N+P+3.
  - PRESET=0 behaves as PRESET=1.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle the FSM clears EN: the CPU write wins.
  - A PRESET write during CNT takes effect at the next LOAD only.
  - Clearing EN mid-count freezes COUNT; re-enabling restarts from LOAD.
- Reset asserted mid-count returns to IDLE immediately (async) and drops irq. Any RAM write in that cycle is still performed if the clock edge occurs while reset is high.

Decomposition:
- Shared package holds:
  - TC_BASE and the register offsets (CTRL=0, PRESET=4, COUNT=8).
  - CTRL bit positions and the MODE encodings.
  - The FSM state encoding (IDLE, LOAD, CNT, INT).
- One sub-module is natural: tc_timer (registers + FSM + irq). data_bridge keeps the decode, the RAM and the read mux.

Test Plan:
- Write 0x11223344 to 0x10 with byteen=1111, then byteen=0100 with wdata 0x00AB0000, read 0x10 -> rdata=0x11AB3344 the same cycle as the address is presented.
- Write 0xDEADBEEF to 0x0000_5000 (unmapped), read it -> 0. Read RAM word 0 immediately after reset -> 0.
- PRESET=3, CTRL=4'b1001 (EN, one-shot, IM) -> COUNT reads 3,2,1,0. irq rises 6 edges after the CTRL write and holds. CTRL bit 0 reads 0. A CTRL write of 0 drops irq.
- PRESET=2, CTRL=4'b1011 (auto-reload) -> irq is a single-cycle pulse. Pulses repeat every 4 cycles (LOAD, CNT×2, INT). COUNT reloads to 2.
- Mid-count with COUNT=5: write CTRL EN=0 -> COUNT frozen at its current value. Write a new PRESET=9 and re-enable -> COUNT=9 after LOAD.
- Assert reset with COUNT=7 and irq=1 -> irq=0, COUNT=0, CTRL=0 asynchronously, with no clock edge needed. RAM contents are preserved.

Source files
------------

// File: rtl/data_bridge_pkg.sv
// Shared definitions for the data-memory bridge: timer address map, CTRL layout,
// FSM encoding and the byte-lane merge helper.
package data_bridge_pkg;

  localparam logic [31:0] TC_BASE = 32'h0000_7F00;

  localparam logic [31:0] TC_CTRL_OFF   = 32'h0000_0000;
  localparam logic [31:0] TC_PRESET_OFF = 32'h0000_0004;
  localparam logic [31:0] TC_COUNT_OFF  = 32'h0000_0008;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Encodings other than auto-reload behave as one-shot.
  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_AUTO    = 2'b01
  } tc_mode_e;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  typedef enum logic [1:0] {
    TC_REG_CTRL   = 2'd0,
    TC_REG_PRESET = 2'd1,
    TC_REG_COUNT  = 2'd2,
    TC_REG_NONE   = 2'd3
  } tc_reg_e;

  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_RAM  = 2'd1,
    REGION_TC   = 2'd2
  } region_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  byteen);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_bridge_tc.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, four-state FSM
// and a registered interrupt request.
module tc_timer
  import data_bridge_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        sel_i,
  input  tc_reg_e     reg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  byteen_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  tc_state_e   state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        irq_q, irq_d;

  logic wr, ctrl_wr, preset_wr, en, auto_reload;

  assign wr          = sel_i && (byteen_i != 4'b0000);
  assign ctrl_wr     = wr && (reg_i == TC_REG_CTRL);
  assign preset_wr   = wr && (reg_i == TC_REG_PRESET);
  assign en          = ctrl_q[CTRL_EN];
  assign auto_reload = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= TC_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every flop samples the pre-edge values.
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_d = state_q;
    unique case (state_q)
      TC_IDLE: if (en) state_d = TC_LOAD;
      TC_LOAD: state_d = TC_CNT;
      TC_CNT: begin
        if (!en)                     state_d = TC_IDLE;
        else if (count_q <= 32'd1)   state_d = TC_INT;
      end
      TC_INT:  state_d = auto_reload ? TC_LOAD : TC_IDLE;
      default: state_d = TC_IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    flag_d   = flag_q;
    unique case (state_q)
      TC_LOAD: count_d = preset_q;
      TC_CNT:  if (en) count_d = (count_q > 32'd1) ? count_q - 32'd1 : '0;
      TC_INT:  if (!auto_reload) ctrl_d[CTRL_EN] = 1'b0;
      default: ;
    endcase

    // A CPU write to CTRL overrides the FSM clearing EN on the same edge.
    if (ctrl_wr && byteen_i[0]) ctrl_d = wdata_i[3:0];
    if (preset_wr) preset_d = merge_bytes(preset_q, wdata_i, byteen_i);

    // One-shot flag is sticky until a CTRL write; auto-reload flag lasts one cycle.
    if (state_q == TC_INT)           flag_d = 1'b1;
    else if (ctrl_wr || auto_reload) flag_d = 1'b0;

    irq_d = ctrl_d[CTRL_IM] & flag_d;
  end

  always_comb begin
    rdata_o = '0;
    unique case (reg_i)
      TC_REG_CTRL:   rdata_o = {28'd0, ctrl_q};
      TC_REG_PRESET: rdata_o = preset_q;
      TC_REG_COUNT:  rdata_o = count_q;
      default:       rdata_o = '0;
    endcase
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/data_bridge.sv
// Data-memory responder: decodes the core's M-stage access into the word RAM,
// the countdown timer, or nothing, and returns combinational read data.
module data_bridge #(
  parameter int          DM_WORDS = 3072,
  parameter logic [31:0] TC_BASE  = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic        irq
);

  import data_bridge_pkg::*;

  localparam int RAM_AW = $clog2(DM_WORDS);

  logic [29:0]       word_idx;
  logic [29:0]       tc_word_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_hit, tc_hit;
  region_e           region;
  tc_reg_e           tc_reg;
  logic [31:0]       tc_rdata;
  logic [31:0]       ram_rdata;
  logic              unused_addr_lsbs;

  assign word_idx         = m_data_addr[31:2];
  assign tc_word_off      = word_idx - TC_BASE[31:2];
  assign ram_idx          = m_data_addr[RAM_AW+1:2];
  assign unused_addr_lsbs = ^m_data_addr[1:0];

  // Unsigned wrap makes addresses below TC_BASE land far outside the 3-word window.
  assign ram_hit = (m_data_addr < 32'(4 * DM_WORDS));
  assign tc_hit  = !ram_hit && (tc_word_off < 30'd3);

  always_comb begin
    region = REGION_NONE;
    if (ram_hit)     region = REGION_RAM;
    else if (tc_hit) region = REGION_TC;
  end

  always_comb begin
    tc_reg = TC_REG_NONE;
    if (tc_word_off == TC_CTRL_OFF[31:2])        tc_reg = TC_REG_CTRL;
    else if (tc_word_off == TC_PRESET_OFF[31:2]) tc_reg = TC_REG_PRESET;
    else if (tc_word_off == TC_COUNT_OFF[31:2])  tc_reg = TC_REG_COUNT;
  end

  // NOTE: the RAM array has no reset; it powers up zero and keeps its contents
  // across reset, so writes still land on an edge while reset is high.
  logic [31:0] ram_q [DM_WORDS];

  always_ff @(posedge clk) begin
    if (ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (m_data_byteen[i]) ram_q[ram_idx][8*i +: 8] <= m_data_wdata[8*i +: 8];
      end
    end
  end

  assign ram_rdata = ram_q[ram_idx];

  tc_timer u_tc (
    .clk_i    (clk),
    .reset_i  (reset),
    .sel_i    (tc_hit),
    .reg_i    (tc_reg),
    .wdata_i  (m_data_wdata),
    .byteen_i (m_data_byteen),
    .rdata_o  (tc_rdata),
    .irq_o    (irq)
  );

  always_comb begin
    m_data_rdata = '0;
    unique case (region)
      REGION_RAM: m_data_rdata = ram_rdata;
      REGION_TC:  m_data_rdata = tc_rdata;
      default:    m_data_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_data_bridge.sv
// Directed bench for data_bridge: RAM byte lanes, decode boundaries, timer
// one-shot / auto-reload / freeze behaviour and asynchronous reset.
module tb_data_bridge;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  data_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (addr),
    .m_data_wdata  (wdata),
    .m_data_byteen (byteen),
    .m_data_rdata  (rdata),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr = a; wdata = d; byteen = be;
    @(posedge clk);
    #1;
    byteen = 4'b0000;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    do_read(32'h0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ram0: got %h want 00000000", d); end
    do_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 00000000", d); end
    do_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h want 00000000", d); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ram_bytes();
    logic [31:0] d;
    do_write(32'h10, 32'h1122_3344, 4'b1111);
    do_write(32'h10, 32'h00AB_0000, 4'b0100);
    do_read(32'h10, d);
    n_checks++;
    if (d !== 32'h11AB_3344) begin n_fail++; $display("FAIL ram_lane_merge: got %h want 11ab3344", d); end
    do_read(32'h13, d);
    n_checks++;
    if (d !== 32'h11AB_3344) begin n_fail++; $display("FAIL ram_addr_lsbs: got %h want 11ab3344", d); end
    do_write(32'h2FFC, 32'hA5A5_5A5A, 4'b1111);
    do_read(32'h2FFC, d);
    n_checks++;
    if (d !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL ram_last_word: got %h want a5a55a5a", d); end
    do_read(32'h0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ram_word0_untouched: got %h want 00000000", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    do_write(32'h5000, 32'hDEAD_BEEF, 4'b1111);
    do_read(32'h5000, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_5000: got %h want 00000000", d); end
    do_write(32'h3000, 32'h1234_5678, 4'b1111);
    do_read(32'h3000, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_ram_end: got %h want 00000000", d); end
    do_read(32'h0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_no_alias: got %h want 00000000", d); end
    do_write(32'h7F0C, 32'hFFFF_FFFF, 4'b1111);
    do_read(32'h7F0C, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_tc_end: got %h want 00000000", d); end
    do_write(A_COUNT, 32'h55, 4'b1111);
    do_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL count_readonly: got %h want 00000000", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic [31:0] exp_count [4] = '{32'd3, 32'd2, 32'd1, 32'd0};
    do_write(A_PRESET, 32'd3, 4'b1111);
    do_write(A_CTRL, 32'h9, 4'b1111);         // EN lands at edge N
    step();                                    // N+1: LOAD
    for (int k = 0; k < 4; k++) begin          // N+2..N+5
      step();
      do_read(A_COUNT, d);
      n_checks++;
      if (d !== exp_count[k]) begin n_fail++; $display("FAIL oneshot_count[%0d]: got %0d want %0d", k, d, exp_count[k]); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_early[%0d]: got %b want 0", k, irq); end
    end
    step();                                    // N+6
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_rise: got %b want 1", irq); end
    do_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL oneshot_en_cleared: got %h want 00000008", d); end
    repeat (3) step();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_hold: got %b want 1", irq); end
    do_write(A_CTRL, 32'h0, 4'b1111);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    logic exp_irq;
    do_write(A_PRESET, 32'd2, 4'b1111);
    do_write(A_CTRL, 32'hB, 4'b1111);         // edge N
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_irq = (k == 5) || (k == 9);
      n_checks++;
      if (irq !== exp_irq) begin n_fail++; $display("FAIL auto_irq[N+%0d]: got %b want %b", k, irq, exp_irq); end
      if (k == 2 || k == 6) begin
        do_read(A_COUNT, d);
        n_checks++;
        if (d !== 32'd2) begin n_fail++; $display("FAIL auto_count_reload[N+%0d]: got %0d want 2", k, d); end
      end
      if (k == 4) begin
        do_read(A_COUNT, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL auto_count_zero: got %0d want 0", d); end
      end
    end
    do_write(A_CTRL, 32'h0, 4'b1111);
  endtask

  task automatic test_freeze();
    logic [31:0] d;
    repeat (2) step();
    do_write(A_PRESET, 32'd8, 4'b1111);
    do_write(A_CTRL, 32'h9, 4'b1111);         // edge N
    repeat (5) step();                         // N+5: COUNT=5
    do_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd5) begin n_fail++; $display("FAIL freeze_pre: got %0d want 5", d); end
    // The decrement already launched on the disabling edge still lands, then COUNT holds.
    do_write(A_CTRL, 32'h0, 4'b1111);
    do_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd4) begin n_fail++; $display("FAIL freeze_edge: got %0d want 4", d); end
    repeat (3) step();
    do_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd4) begin n_fail++; $display("FAIL freeze_hold: got %0d want 4", d); end
    do_write(A_PRESET, 32'd9, 4'b1111);
    do_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd4) begin n_fail++; $display("FAIL freeze_preset_no_load: got %0d want 4", d); end
    do_write(A_CTRL, 32'h9, 4'b1111);         // edge E
    repeat (2) step();
    do_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd9) begin n_fail++; $display("FAIL reenable_load: got %0d want 9", d); end
    do_write(A_PRESET, 32'd2, 4'b1111);       // during CNT: no effect on COUNT
    do_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd8) begin n_fail++; $display("FAIL preset_during_cnt: got %0d want 8", d); end
    do_write(A_CTRL, 32'h0, 4'b1111);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    repeat (2) step();
    do_write(A_PRESET, 32'd1, 4'b1111);
    do_write(A_CTRL, 32'h9, 4'b1111);         // edge N, irq at N+4
    repeat (4) step();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL arst_irq_before: got %b want 1", irq); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL arst_irq_drop: got %b want 0", irq); end
    do_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL arst_ctrl: got %h want 00000000", d); end
    do_read(A_PRESET, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL arst_preset: got %h want 00000000", d); end
    do_write(32'h20, 32'hCAFE_F00D, 4'b1111); // RAM write on an edge while reset is high
    @(negedge clk);
    reset = 1'b0;
    do_read(32'h20, d);
    n_checks++;
    if (d !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL arst_ram_write: got %h want cafef00d", d); end
    do_read(32'h10, d);
    n_checks++;
    if (d !== 32'h11AB_3344) begin n_fail++; $display("FAIL arst_ram_kept: got %h want 11ab3344", d); end

    do_write(A_PRESET, 32'd7, 4'b1111);
    do_write(A_CTRL, 32'h9, 4'b1111);         // edge N, COUNT=7 at N+2
    repeat (2) step();
    do_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd7) begin n_fail++; $display("FAIL arst_count_pre: got %0d want 7", d); end
    #2 reset = 1'b1;
    #1;
    do_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL arst_count: got %0d want 0", d); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step();
    do_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL arst_stays_idle: got %0d want 0", d); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL arst_irq_after: got %b want 0", irq); end
  endtask

  initial begin
    reset  = 1'b1;
    addr   = '0;
    wdata  = '0;
    byteen = 4'b0000;
    test_reset();
    test_ram_bytes();
    test_unmapped();
    test_oneshot();
    test_autoreload();
    test_freeze();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
